uart_tx_word_ctrl: RTL and testbench

- Drains words from a PeriPlex FIFO and feeds a uart_tx-style transmitter one character at a time. Each FIFO word of FIFO_WIDTH bits is split into BYTES = FIFO_WIDTH/UART_DATA_WIDTH characters.
- Next generation of the byte-wide FIFO-to-UART controller. Adds configurable FIFO read latency, character order, inter-character gap, an enable, a busy flag and a per-word completion pulse.
- Sits between the peripheral TX FIFO and uart_tx inside the UART slave peripheral.

---
 rtl/uart_tx_word_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_tx_word_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_ctrl.sv
// Word-wide FIFO to uart_tx bridge: pops one FIFO word and
// streams its slices as single characters with optional gaps.
module uart_tx_word_ctrl #(
  parameter int FIFO_WIDTH      = 32,
  parameter int UART_DATA_WIDTH = 8,
  parameter int MSB_FIRST       = 0,
  parameter int FIFO_RD_LATENCY = 1,
  parameter int GAP_CYCLES      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       f_empty,
  input  logic [FIFO_WIDTH-1:0]      fifo_read_data,
  output logic                       fifo_read_en,
  input  logic                       uart_tx_done,
  output logic                       uart_dv,
  output logic [UART_DATA_WIDTH-1:0] uart_data,
  output logic                       busy,
  output logic                       word_done
);

  localparam int BYTES = FIFO_WIDTH / UART_DATA_WIDTH;
  localparam logic [2:0] LAT_LD = 3'(FIFO_RD_LATENCY - 1);
  localparam logic [7:0] GAP_LD =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, LOAD, SEND, ACK, GAP
  } state_t;

  state_t state, state_n;

  logic [FIFO_WIDTH-1:0]      sreg, sreg_n, src;
  logic [3:0]                 slices, slices_n;
  logic [2:0]                 lat, lat_n;
  logic [7:0]                 gap, gap_n;
  logic [UART_DATA_WIDTH-1:0] data_n;
  logic                       done_n;

  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    slices_n = slices;
    lat_n    = lat;
    gap_n    = gap;
    data_n   = uart_data;
    done_n   = 1'b0;
    src      = (state == LOAD) ? fifo_read_data : sreg;

    unique case (state)
      IDLE: if (enable && !f_empty) state_n = READ;
      READ: begin
        lat_n   = LAT_LD;
        state_n = (FIFO_RD_LATENCY == 1) ? LOAD : WAIT;
      end
      WAIT: begin
        lat_n = lat - 3'd1;
        if (lat <= 3'd1) state_n = LOAD;
      end
      LOAD: begin
        slices_n = 4'(BYTES);
        state_n  = SEND;
      end
      SEND: state_n = ACK;
      ACK: if (uart_tx_done) begin
        slices_n = slices - 4'd1;
        if (GAP_CYCLES > 0) begin
          state_n = GAP;
          gap_n   = GAP_LD;
        end else if (slices > 4'd1) begin
          state_n = SEND;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        if (gap != 8'd0) begin
          gap_n = gap - 8'd1;
        end else if (slices != 4'd0) begin
          state_n = SEND;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Character is picked and the word shifted on entry to SEND
    if (state_n == SEND) begin
      if (MSB_FIRST != 0) begin
        data_n = src[FIFO_WIDTH-1 -: UART_DATA_WIDTH];
        sreg_n = src << UART_DATA_WIDTH;
      end else begin
        data_n = src[UART_DATA_WIDTH-1:0];
        sreg_n = src >> UART_DATA_WIDTH;
      end
    end
    if (done_n) data_n = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sreg         <= '0;
      slices       <= '0;
      lat          <= '0;
      gap          <= '0;
      fifo_read_en <= 1'b0;
      uart_dv      <= 1'b0;
      uart_data    <= '0;
      busy         <= 1'b0;
      word_done    <= 1'b0;
    end else begin
      state        <= state_n;
      sreg         <= sreg_n;
      slices       <= slices_n;
      lat          <= lat_n;
      gap          <= gap_n;
      fifo_read_en <= (state_n == READ);
      uart_dv      <= (state_n == SEND);
      uart_data    <= data_n;
      busy         <= (state_n != IDLE);
      word_done    <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_word_ctrl.sv
// Bench: four controller configurations share one word stream;
// an event-level model predicts every strobe, character and flag.
module tb_uart_tx_word_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] wlist[$];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int inst,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc %0d: got %0h want %0h",
               name, inst, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int MSB = gi % 2;
    localparam int LAT = (gi < 2) ? 1 : gi + 1;
    localparam int GAP = (gi == 2) ? 3 : ((gi == 3) ? 1 : 0);

    logic        f_empty;
    logic        fifo_read_en;
    logic        uart_tx_done;
    logic        uart_dv;
    logic        busy;
    logic        word_done;
    logic [31:0] fifo_read_data;
    logic [7:0]  uart_data;

    uart_tx_word_ctrl #(
      .FIFO_WIDTH(32),
      .UART_DATA_WIDTH(8),
      .MSB_FIRST(MSB),
      .FIFO_RD_LATENCY(LAT),
      .GAP_CYCLES(GAP)
    ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .f_empty(f_empty),
      .fifo_read_data(fifo_read_data),
      .fifo_read_en(fifo_read_en),
      .uart_tx_done(uart_tx_done),
      .uart_dv(uart_dv),
      .uart_data(uart_data),
      .busy(busy),
      .word_done(word_done)
    );

    // FIFO with read latency, plus a randomly slow transmitter
    int          rd_ptr = 0;
    int          due = -1;
    logic [31:0] dword = '0;
    bit          ack_pend = 1'b0;

    initial begin
      f_empty        = 1'b1;
      fifo_read_data = '0;
      uart_tx_done   = 1'b0;
      forever begin
        @(posedge clk);
        #1;
        if (fifo_read_en && rd_ptr < wlist.size()) begin
          dword = wlist[rd_ptr];
          rd_ptr++;
          due = cyc + LAT;
        end
        fifo_read_data = (cyc == due) ? dword : $urandom;
        f_empty = (rd_ptr >= wlist.size());
        if (uart_dv) begin
          ack_pend = 1'b1;
          uart_tx_done = ($urandom_range(0, 3) == 0);
        end else if (ack_pend) begin
          uart_tx_done = ($urandom_range(0, 2) == 0);
          if (uart_tx_done) ack_pend = 1'b0;
        end else begin
          uart_tx_done = ($urandom_range(0, 11) == 0);
        end
      end
    end

    // Model: expected strobe times and character stream
    bit          in_word = 1'b0;
    bit          waiting = 1'b0;
    bit          rst_prev = 1'b0;
    bit          exp_read = 1'b0;
    bit          quiet = 1'b1;
    int          m_ptr = 0;
    int          exp_dv = -1;
    int          exp_wd = -1;
    int          last_ack = -1;
    int          dv_cnt = 0;
    int          rd_cnt = 0;
    int          wd_cnt = 0;
    int          first_rd = -1;
    int          first_dv = -1;
    int          ack2dv = -1;
    int          ack2wd = -1;
    logic [7:0]  chars[$];
    logic [7:0]  dlog[$];
    logic [7:0]  held = '0;
    logic [31:0] w;

    initial forever begin
      @(negedge clk);
      if (rst_prev) begin
        chk("reset_outputs", gi,
            64'({fifo_read_en, uart_dv, uart_data, busy, word_done}),
            64'(0));
        in_word = 1'b0;
        waiting = 1'b0;
        chars.delete();
        exp_dv = -1;
        exp_wd = -1;
      end else begin
        chk("fifo_read_en", gi, 64'(fifo_read_en), 64'(exp_read));
        if (exp_read && m_ptr < wlist.size()) begin
          w = wlist[m_ptr];
          m_ptr++;
          rd_cnt++;
          in_word = 1'b1;
          exp_dv = cyc + LAT + 1;
          if (first_rd < 0) first_rd = cyc;
          for (int k = 0; k < 4; k++)
            chars.push_back(8'(w >> (8 * (MSB != 0 ? 3 - k : k))));
        end
        chk("uart_dv", gi, 64'(uart_dv), 64'(cyc == exp_dv));
        if (cyc == exp_dv) begin
          held = (chars.size() > 0) ? chars.pop_front() : 8'hxx;
          chk("uart_data_char", gi, 64'(uart_data), 64'(held));
          dlog.push_back(uart_data);
          dv_cnt++;
          waiting = 1'b1;
          if (first_dv < 0) first_dv = cyc;
          if (last_ack >= 0 && ack2dv < 0) ack2dv = cyc - last_ack;
        end else if (waiting) begin
          chk("uart_data_hold", gi, 64'(uart_data), 64'(held));
          if (uart_tx_done) begin
            waiting = 1'b0;
            last_ack = cyc;
            if (chars.size() > 0) exp_dv = cyc + GAP + 1;
            else exp_wd = cyc + GAP + 1;
          end
        end
        chk("word_done", gi, 64'(word_done), 64'(cyc == exp_wd));
        if (cyc == exp_wd) begin
          chk("uart_data_clear", gi, 64'(uart_data), 64'(0));
          in_word = 1'b0;
          wd_cnt++;
          if (ack2wd < 0) ack2wd = cyc - last_ack;
        end
        chk("busy", gi, 64'(busy), 64'(in_word));
      end
      exp_read = !in_word && enable && !f_empty && !rst;
      rst_prev = rst;
      quiet = !in_word && (m_ptr >= wlist.size());
    end
  end

  task automatic push(input logic [31:0] v);
    wlist.push_back(v);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    repeat (3) @(posedge clk);
    #2;
    while (!(g_inst[0].quiet && g_inst[1].quiet &&
             g_inst[2].quiet && g_inst[3].quiet) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) chk("timeout_quiet", 0, 64'(1), 64'(0));
  endtask

  task automatic wait_dv0(input int target, input int budget);
    int n = 0;
    while (g_inst[0].dv_cnt < target && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) chk("timeout_dv", 0, 64'(1), 64'(0));
  endtask

  logic [7:0] e_lsb[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [7:0] e_msb[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
  logic [7:0] e2_lsb[8] = '{8'h44, 8'h33, 8'h22, 8'h11,
                            8'h88, 8'h77, 8'h66, 8'h55};
  logic [7:0] e2_msb[8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                            8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] e4[4] = '{8'hE0, 8'hAC, 8'h68, 8'h24};

  initial begin
    int base;
    int wd0;
    int sz;
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    push(32'hA1B2C3D4);
    enable = 1'b1;
    wait_quiet(400);
    for (int k = 0; k < 4; k++) begin
      chk("p1_lsb_order", 0, 64'(g_inst[0].dlog[k]), 64'(e_lsb[k]));
      chk("p1_msb_order", 1, 64'(g_inst[1].dlog[k]), 64'(e_msb[k]));
    end
    chk("p1_rd_to_dv", 0,
        64'(g_inst[0].first_dv - g_inst[0].first_rd), 64'(2));
    chk("p1_rd_to_dv", 2,
        64'(g_inst[2].first_dv - g_inst[2].first_rd), 64'(4));
    chk("p1_ack_to_dv", 0, 64'(g_inst[0].ack2dv), 64'(1));
    chk("p1_ack_to_dv", 2, 64'(g_inst[2].ack2dv), 64'(4));
    chk("p1_ack_to_wd", 2, 64'(g_inst[2].ack2wd), 64'(4));
    chk("p1_reads", 0, 64'(g_inst[0].rd_cnt), 64'(1));
    chk("p1_word_done", 0, 64'(g_inst[0].wd_cnt), 64'(1));

    push(32'h11223344);
    push(32'h55667788);
    wait_quiet(800);
    for (int k = 0; k < 8; k++) begin
      chk("p2_lsb_order", 0, 64'(g_inst[0].dlog[4 + k]), 64'(e2_lsb[k]));
      chk("p2_msb_order", 1, 64'(g_inst[1].dlog[4 + k]), 64'(e2_msb[k]));
    end
    chk("p2_reads", 1, 64'(g_inst[1].rd_cnt), 64'(3));
    chk("p2_word_done", 1, 64'(g_inst[1].wd_cnt), 64'(3));

    base = g_inst[0].dv_cnt;
    push(32'hCAFEF00D);
    push(32'h0BADBEEF);
    wait_dv0(base + 2, 300);
    enable = 1'b0;
    repeat (80) @(posedge clk);
    #2;
    sz = wlist.size();
    chk("p3_no_new_read", 0, 64'(g_inst[0].m_ptr), 64'(sz - 1));
    chk("p3_no_new_read", 2, 64'(g_inst[2].m_ptr), 64'(sz - 1));
    chk("p3_word_finished", 0, 64'(g_inst[0].dv_cnt), 64'(base + 4));
    enable = 1'b1;
    wait_quiet(800);

    base = g_inst[0].dv_cnt;
    wd0 = g_inst[0].wd_cnt;
    push(32'h13579BDF);
    wait_dv0(base + 2, 300);
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    chk("p4_no_word_done", 0, 64'(g_inst[0].wd_cnt), 64'(wd0));
    base = g_inst[0].dv_cnt;
    push(32'h2468ACE0);
    wait_quiet(400);
    for (int k = 0; k < 4; k++)
      chk("p4_restart_order", 0,
          64'(g_inst[0].dlog[base + k]), 64'(e4[k]));
    chk("p4_word_done", 0, 64'(g_inst[0].wd_cnt), 64'(wd0 + 1));

    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 11) == 0) push($urandom);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
    end
    enable = 1'b1;
    wait_quiet(4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
